fm_demodulator: RTL and testbench
=================================

FM_DEMODULATOR -- requirements
Module: fm_demodulator

Interface
REQ-001 SHALL have parameter A, default 8, audio output width in bits.
REQ-002 SHALL have parameter D, default 5, rf input width in bits (offset binary, midscale 2^(D-1)).
REQ-003 SHALL have parameter F_S, default 50000000, sampling clock frequency in Hz.
REQ-004 SHALL have parameter F_C, default 10000000, nominal carrier frequency in Hz.
REQ-005 SHALL have parameter DF, default 75000, full-scale frequency deviation in Hz.
REQ-006 SHALL have parameter K, default 20, log2 of measurement window length W = 2^K clocks.
REQ-007 SHALL have parameter H, default 2, comparator hysteresis in rf LSBs.
REQ-008 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-009 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-010 SHALL have port rf, input, D, FM-modulated samples, offset binary.
REQ-011 SHALL have port audio, output, A, recovered audio, signed 2's complement.
REQ-012 SHALL have port audio_valid, output, 1, single-cycle strobe marking a new audio value.
REQ-013 SHALL have port carrier_ok, output, 1, carrier present and within lock range for the last window.

Function
REQ-014 SHALL register rf once before the crossing comparison; every downstream latency counts from this register.
REQ-015 SHALL track a level bit: set when sample >= 2^(D-1)+H, clear when sample <= 2^(D-1)-H, otherwise hold.
REQ-016 SHALL count one crossing per 0->1 transition of the level bit; 1->0 transitions SHALL NOT be counted.
REQ-017 SHALL run a free-running window counter 0..W-1 that wraps to 0 after W-1.
REQ-018 SHALL add a crossing occurring in the window's last cycle (count W-1) to that window, then restart the crossing count from 0 (or from 1 if a crossing occurs in cycle 0 of the next window).
REQ-019 SHALL compute elaboration-time constants NOM = floor(F_C*W/F_S) and DEV = max(1, floor(DF*W/F_S)).
REQ-020 SHALL form diff = count - NOM as a signed value wide enough for the range -NOM..W-NOM without overflow.
REQ-021 SHALL scale to diff*2^(A-1)/DEV, truncating toward zero, then saturate to [-2^(A-1), 2^(A-1)-1].
REQ-022 SHALL update audio and pulse audio_valid high for exactly one cycle, 1 cycle after the window's last cycle.
REQ-023 SHALL hold audio between strobes.
REQ-024 SHALL update carrier_ok together with audio: 1 iff |diff| <= 2*DEV, else 0.
REQ-025 SHALL implement state machine WARMUP -> RUN.
REQ-026 In WARMUP, the first complete window after reset SHALL be measured but discarded, with no strobe and audio/carrier_ok held.
REQ-027 At the end of the first window the machine SHALL enter RUN, which is terminal until reset.
REQ-028 SHALL assume the level bit is 0 after reset, so a sample already high on the first cycle counts as a crossing.

Reset
REQ-029 While rst_n=0 at a clock edge: audio=0, audio_valid=0, carrier_ok=0, window counter=0, crossing count=0, level bit=0, state=WARMUP.
REQ-030 Reset asserted mid-window SHALL discard the partial window with no strobe; measurement restarts from window counter 0 after release.

Structure
REQ-031 A, D, F_S, F_C, DF defaults SHALL live in a shared package fm_pkg, used by modulator and demodulator alike.
REQ-032 NOM, DEV and the diff width SHALL be localparams derived in the module from those parameters.
REQ-033 The registered hysteresis comparator and edge detect SHALL be sub-module zero_cross_det (inputs clk, rst_n, rf; output crossing strobe).
REQ-034 Division SHALL be by elaboration-time constant only; no runtime divider.

Verification (run with K=12 override: W=4096, NOM=819, DEV=6)
REQ-035 Constant rf=16 for 3 windows -> no crossings; after warmup, audio=-128, carrier_ok=0, strobe once per 4096 cycles.
REQ-036 Square wave 0/31, period 5 -> count 819 or 820 -> audio 0 or 21, carrier_ok=1.
REQ-037 Square wave period 4 -> count 1024, diff 205 -> audio=127 (saturated), carrier_ok=0.
REQ-038 Sine amplitude ±1 LSB around 16 with H=2 -> no crossings counted -> audio=-128, carrier_ok=0.
REQ-039 Reset pulse at window cycle 2000, period-5 input -> no strobe for that window.
REQ-040 REQ-039 continued: after reset release, first strobe exactly 2*4096+1 cycles later (warmup window discarded).

Source files
------------

// File: rtl/fm_pkg.sv
// Shared defaults and types for the FM modulator/demodulator pair.
package fm_pkg;

  // Default audio width, rf width, sample rate, carrier and full-scale deviation
  localparam int FM_A   = 8;
  localparam int FM_D   = 5;
  localparam int FM_F_S = 50000000;
  localparam int FM_F_C = 10000000;
  localparam int FM_DF  = 75000;

  // Demodulator control states: first window after reset is thrown away
  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } fm_state_t;

  // Clamp an elaboration-time quantity to at least one (used for the deviation divisor)
  function automatic longint fm_max1(input longint v);
    if (v < 64'sd1) begin
      return 64'sd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/zero_cross_det.sv
// Registered rf sample, hysteresis comparator and rising-edge crossing strobe.
module zero_cross_det
  import fm_pkg::*;
#(
  parameter int D = FM_D,
  parameter int H = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [D-1:0] rf,
  output logic         crossing
);

  // Thresholds held one bit wider and signed so large H cannot wrap
  localparam int MID = 1 << (D - 1);
  localparam logic signed [D+1:0] TH_HI = (D + 2)'(MID + H);
  localparam logic signed [D+1:0] TH_LO = (D + 2)'(MID - H);

  logic [D-1:0]        r_rf;
  logic                r_level;
  logic                w_level_next;
  logic signed [D+1:0] w_sample;

  assign w_sample = $signed({2'b00, r_rf});

  // Input sample register and level bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rf    <= {D{1'b0}};
      r_level <= 1'b0;
    end else begin
      r_rf    <= rf;
      r_level <= w_level_next;
    end
  end

  // Hysteresis: set above the upper threshold, clear below the lower, hold between
  always_comb begin
    w_level_next = r_level;
    if (w_sample >= TH_HI) begin
      w_level_next = 1'b1;
    end else if (w_sample <= TH_LO) begin
      w_level_next = 1'b0;
    end else begin
      w_level_next = r_level;
    end
  end

  // Only 0->1 transitions of the level bit count as crossings
  assign crossing = w_level_next & ~r_level;

endmodule

// File: rtl/fm_demodulator.sv
// Crossing-count FM demodulator: counts carrier rising crossings per 2^K-clock
// window and maps the deviation from the nominal count to signed audio.
module fm_demodulator
  import fm_pkg::*;
#(
  parameter int A   = FM_A,
  parameter int D   = FM_D,
  parameter int F_S = FM_F_S,
  parameter int F_C = FM_F_C,
  parameter int DF  = FM_DF,
  parameter int K   = 20,
  parameter int H   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [D-1:0] rf,
  output logic [A-1:0] audio,
  output logic         audio_valid,
  output logic         carrier_ok
);

  // Count holds 0..W, diff spans -NOM..W-NOM, scaled product needs A more bits
  localparam int     CW    = K + 1;
  localparam int     DW    = K + 2;
  localparam int     SW    = DW + A;
  localparam longint W_L   = 64'sd1 <<< K;
  localparam longint NOM_L = (longint'(F_C) * W_L) / longint'(F_S);
  localparam longint DEV_L = fm_max1((longint'(DF) * W_L) / longint'(F_S));

  localparam logic signed [DW-1:0] NOM      = DW'(NOM_L);
  localparam logic signed [DW-1:0] DEV2     = DW'(DEV_L * 64'sd2);
  localparam logic signed [SW-1:0] DEV_S    = SW'(DEV_L);
  localparam logic signed [SW-1:0] SAT_HI   = SW'((64'sd1 <<< (A - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_LO   = SW'(-(64'sd1 <<< (A - 1)));
  localparam logic [K-1:0]         WIN_LAST = {K{1'b1}};

  fm_state_t r_state;
  fm_state_t w_state_next;

  logic [K-1:0]         r_win;
  logic [CW-1:0]        r_cnt;
  logic [A-1:0]         r_audio;
  logic                 r_valid;
  logic                 r_ok;
  logic                 w_cross;
  logic                 w_win_end;
  logic                 w_strobe;
  logic [CW-1:0]        w_total;
  logic signed [DW-1:0] w_diff;
  logic signed [DW-1:0] w_abs;
  logic signed [SW-1:0] w_num;
  logic signed [SW-1:0] w_quot;
  logic [A-1:0]         w_audio_next;
  logic                 w_ok;

  zero_cross_det #(
    .D (D),
    .H (H)
  ) u_zcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .rf       (rf),
    .crossing (w_cross)
  );

  // A crossing in the last window cycle still belongs to the closing window
  assign w_win_end = (r_win == WIN_LAST);
  assign w_total   = r_cnt + CW'(w_cross);
  assign w_diff    = $signed({1'b0, w_total}) - NOM;
  assign w_abs     = (w_diff < $signed({DW{1'b0}})) ? -w_diff : w_diff;
  assign w_num     = $signed({{A{w_diff[DW-1]}}, w_diff}) <<< (A - 1);
  assign w_quot    = w_num / DEV_S;
  assign w_ok      = (w_abs <= DEV2);

  // Saturate the scaled deviation to the signed audio range
  always_comb begin
    w_audio_next = w_quot[A-1:0];
    if (w_quot > SAT_HI) begin
      w_audio_next = SAT_HI[A-1:0];
    end else if (w_quot < SAT_LO) begin
      w_audio_next = SAT_LO[A-1:0];
    end else begin
      w_audio_next = w_quot[A-1:0];
    end
  end

  // Control next state: the warmup window closes silently, RUN strobes every window
  always_comb begin
    w_state_next = r_state;
    w_strobe     = 1'b0;
    case (r_state)
      ST_WARMUP: begin
        if (w_win_end) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_WARMUP;
        end
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
        if (w_win_end) begin
          w_strobe = 1'b1;
        end else begin
          w_strobe = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_WARMUP;
        w_strobe     = 1'b0;
      end
    endcase
  end

  // Window counter, crossing accumulator, state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win   <= {K{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_state <= ST_WARMUP;
      r_audio <= {A{1'b0}};
      r_valid <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      r_win   <= r_win + {{(K - 1){1'b0}}, 1'b1};
      r_cnt   <= w_win_end ? {CW{1'b0}} : w_total;
      r_state <= w_state_next;
      r_valid <= w_strobe;
      if (w_strobe) begin
        r_audio <= w_audio_next;
        r_ok    <= w_ok;
      end else begin
        r_audio <= r_audio;
        r_ok    <= r_ok;
      end
    end
  end

  assign audio       = r_audio;
  assign audio_valid = r_valid;
  assign carrier_ok  = r_ok;

endmodule

// File: tb/tb_fm_demodulator.sv
// Directed bench for fm_demodulator with K=12 (W=4096, NOM=819, DEV=6).
module tb_fm_demodulator;

  localparam int WIN = 4096;

  logic              clk;
  logic              rst_n;
  logic [4:0]        rf;
  logic signed [7:0] audio;
  logic              audio_valid;
  logic              carrier_ok;

  int total;
  int bad;
  int mode;
  int phase;
  int cyc;
  int hold_viol;
  logic [7:0] prev_audio;

  int                sq_cyc[$];
  logic signed [7:0] sq_aud[$];
  logic              sq_ok[$];

  fm_demodulator #(
    .K (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rf          (rf),
    .audio       (audio),
    .audio_valid (audio_valid),
    .carrier_ok  (carrier_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus patterns: 0 const midscale, 1 square period 5, 2 square period 4, 3 +/-1 LSB wobble
  function automatic logic [4:0] pat(input int m, input int p);
    logic [4:0] v;
    case (m)
      0: v = 5'd16;
      1: v = ((p % 5) < 2) ? 5'd0 : 5'd31;
      2: v = ((p % 4) < 2) ? 5'd0 : 5'd31;
      3: begin
        case (p % 4)
          0: v = 5'd16;
          1: v = 5'd17;
          2: v = 5'd16;
          default: v = 5'd15;
        endcase
      end
      default: v = 5'd16;
    endcase
    return v;
  endfunction

  // Synchronous reset; returns at the negedge of the first released cycle (cycle 1)
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rf    = 5'd16;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 1;
    phase = 0;
    hold_viol = 0;
    prev_audio = audio;
    sq_cyc.delete();
    sq_aud.delete();
    sq_ok.delete();
  endtask

  // Drive n cycles of the current pattern, logging strobes and audio hold behaviour
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (audio_valid === 1'b1) begin
        sq_cyc.push_back(cyc);
        sq_aud.push_back(audio);
        sq_ok.push_back(carrier_ok);
      end else if (audio !== prev_audio) begin
        hold_viol++;
      end
      prev_audio = audio;
      rf = pat(mode, phase);
      phase++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    mode = 0;
    do_reset();
    total++;
    if (audio !== 8'sd0) begin
      bad++;
      $display("FAIL reset_audio: got %0d want 0", audio);
    end
    total++;
    if (audio_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0", audio_valid);
    end
    total++;
    if (carrier_ok !== 1'b0) begin
      bad++;
      $display("FAIL reset_carrier: got %b want 0", carrier_ok);
    end
  endtask

  task automatic test_constant();
    mode = 0;
    do_reset();
    run(3 * WIN + 2);
    total++;
    if (sq_cyc.size() != 2) begin
      bad++;
      $display("FAIL const_strobes: got %0d want 2", sq_cyc.size());
    end
    if (sq_cyc.size() >= 1) begin
      total++;
      if (sq_cyc[0] != 2 * WIN + 1) begin
        bad++;
        $display("FAIL const_first_strobe: got cycle %0d want %0d", sq_cyc[0], 2 * WIN + 1);
      end
    end
    if (sq_cyc.size() >= 2) begin
      total++;
      if (sq_cyc[1] - sq_cyc[0] != WIN) begin
        bad++;
        $display("FAIL const_spacing: got %0d want %0d", sq_cyc[1] - sq_cyc[0], WIN);
      end
    end
    foreach (sq_aud[i]) begin
      total++;
      if (sq_aud[i] !== -8'sd128) begin
        bad++;
        $display("FAIL const_audio[%0d]: got %0d want -128", i, sq_aud[i]);
      end
      total++;
      if (sq_ok[i] !== 1'b0) begin
        bad++;
        $display("FAIL const_carrier[%0d]: got %b want 0", i, sq_ok[i]);
      end
    end
    total++;
    if (hold_viol != 0) begin
      bad++;
      $display("FAIL const_hold: got %0d changes between strobes want 0", hold_viol);
    end
  endtask

  task automatic test_period5();
    mode = 1;
    do_reset();
    run(3 * WIN + 2);
    total++;
    if (sq_cyc.size() != 2) begin
      bad++;
      $display("FAIL p5_strobes: got %0d want 2", sq_cyc.size());
    end
    foreach (sq_aud[i]) begin
      total++;
      if (sq_aud[i] !== 8'sd0 && sq_aud[i] !== 8'sd21) begin
        bad++;
        $display("FAIL p5_audio[%0d]: got %0d want 0 or 21", i, sq_aud[i]);
      end
      total++;
      if (sq_ok[i] !== 1'b1) begin
        bad++;
        $display("FAIL p5_carrier[%0d]: got %b want 1", i, sq_ok[i]);
      end
    end
    total++;
    if (hold_viol != 0) begin
      bad++;
      $display("FAIL p5_hold: got %0d changes between strobes want 0", hold_viol);
    end
  endtask

  task automatic test_period4();
    mode = 2;
    do_reset();
    run(2 * WIN + 2);
    total++;
    if (sq_cyc.size() != 1) begin
      bad++;
      $display("FAIL p4_strobes: got %0d want 1", sq_cyc.size());
    end
    foreach (sq_aud[i]) begin
      total++;
      if (sq_aud[i] !== 8'sd127) begin
        bad++;
        $display("FAIL p4_audio[%0d]: got %0d want 127", i, sq_aud[i]);
      end
      total++;
      if (sq_ok[i] !== 1'b0) begin
        bad++;
        $display("FAIL p4_carrier[%0d]: got %b want 0", i, sq_ok[i]);
      end
    end
  endtask

  task automatic test_small_sine();
    mode = 3;
    do_reset();
    run(2 * WIN + 2);
    total++;
    if (sq_cyc.size() != 1) begin
      bad++;
      $display("FAIL sine_strobes: got %0d want 1", sq_cyc.size());
    end
    foreach (sq_aud[i]) begin
      total++;
      if (sq_aud[i] !== -8'sd128) begin
        bad++;
        $display("FAIL sine_audio[%0d]: got %0d want -128", i, sq_aud[i]);
      end
      total++;
      if (sq_ok[i] !== 1'b0) begin
        bad++;
        $display("FAIL sine_carrier[%0d]: got %b want 0", i, sq_ok[i]);
      end
    end
  endtask

  task automatic test_reset_midwindow();
    mode = 1;
    do_reset();
    // warmup + one strobed window, then 2000 cycles into the next window
    run(2 * WIN + 2000);
    total++;
    if (sq_cyc.size() != 1) begin
      bad++;
      $display("FAIL mid_pre_strobes: got %0d want 1", sq_cyc.size());
    end
    do_reset();
    total++;
    if (audio !== 8'sd0) begin
      bad++;
      $display("FAIL mid_reset_audio: got %0d want 0", audio);
    end
    run(2 * WIN + 8);
    total++;
    if (sq_cyc.size() != 1) begin
      bad++;
      $display("FAIL mid_post_strobes: got %0d want 1", sq_cyc.size());
    end
    if (sq_cyc.size() >= 1) begin
      total++;
      if (sq_cyc[0] != 2 * WIN + 1) begin
        bad++;
        $display("FAIL mid_first_strobe: got cycle %0d want %0d", sq_cyc[0], 2 * WIN + 1);
      end
      total++;
      if (sq_aud[0] !== 8'sd0 && sq_aud[0] !== 8'sd21) begin
        bad++;
        $display("FAIL mid_audio: got %0d want 0 or 21", sq_aud[0]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mode  = 0;
    phase = 0;
    cyc   = 0;
    hold_viol = 0;
    rst_n = 1'b0;
    rf    = 5'd16;
    prev_audio = 8'd0;
    test_reset();
    test_constant();
    test_period5();
    test_period4();
    test_small_sine();
    test_reset_midwindow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
